// File: rtl/mac_seq_pkg.sv
// Shared types, default widths and the single-step multiply-add rule
// used by the MAC sequencer and its accumulator datapath.
package mac_seq_pkg;

  localparam int MAC_W     = 16;
  localparam int MAC_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {wrap_bit, next_acc}: wrap_bit flags a product wider than W
  // bits or a carry out of the accumulate.
  function automatic logic [MAC_W:0] mac_step(input logic [MAC_W-1:0] acc,
                                              input logic [MAC_W-1:0] a,
                                              input logic [MAC_W-1:0] b);
    logic [2*MAC_W-1:0] p;
    logic [MAC_W:0]     s;
    p = {{MAC_W{1'b0}}, a} * {{MAC_W{1'b0}}, b};
    s = {1'b0, acc} + {1'b0, p[MAC_W-1:0]};
    return {(p[2*MAC_W-1:MAC_W] != '0) | s[MAC_W], s[MAC_W-1:0]};
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Job, operand-stream and result handshake bundle between the job issuer
// (master) and the MAC sequencer (slave).
interface mac_seq_ctrl_if #(
  parameter int W     = mac_seq_pkg::MAC_W,
  parameter int CNT_W = mac_seq_pkg::MAC_CNT_W
);

  logic             start;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a_in;
  logic [W-1:0]     b_in;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res;
  logic             wrap;

  modport master (
    output start, len, abort, in_valid, a_in, b_in, res_ready,
    input  busy, in_ready, res_valid, res, wrap
  );

  modport slave (
    input  start, len, abort, in_valid, a_in, b_in, res_ready,
    output busy, in_ready, res_valid, res, wrap
  );

endinterface

// File: rtl/mac_acc_dp.sv
// Multiply-add accumulator with synchronous clear and a sticky wrap flag;
// clr has priority over en.
module mac_acc_dp
  import mac_seq_pkg::*;
#(
  parameter int W = MAC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] acc,
  output logic         wrap
);

  logic [W-1:0] r_acc;
  logic         r_wrap;
  logic [W:0]   w_step;

  // The package helper is fixed at the default width; other widths use
  // the same rule written generically.
  generate
    if (W == MAC_W) begin : g_pkg_step
      assign w_step = mac_step(r_acc, a, b);
    end else begin : g_generic_step
      logic [2*W-1:0] w_prod;
      logic [W:0]     w_sum;
      assign w_prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      assign w_sum  = {1'b0, r_acc} + {1'b0, w_prod[W-1:0]};
      assign w_step = {(w_prod[2*W-1:W] != '0) | w_sum[W], w_sum[W-1:0]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (clr) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_acc  <= w_step[W-1:0];
      r_wrap <= r_wrap | w_step[W];
    end
  end

  assign acc  = r_acc;
  assign wrap = r_wrap;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the MAC datapath: FSM, beat counter and handshakes.
// The accumulator itself lives in mac_acc_dp.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int W     = MAC_W,
  parameter int CNT_W = MAC_CNT_W
) (
  input logic           clk,
  input logic           rst,
  mac_seq_ctrl_if.slave bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_beat;
  logic             w_clr;
  logic             w_en;
  logic [W-1:0]     w_acc;
  logic             w_wrap;

  assign w_beat = (r_state == RUN) && bus.in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // abort overrides every other event in the same cycle
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (bus.abort) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            w_cnt_next   = bus.len;
            w_state_next = (bus.len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (w_beat) begin
            w_cnt_next = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              w_state_next = DONE;
            end
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            w_state_next = IDLE;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.busy      = (r_state != IDLE);
    bus.in_ready  = (r_state == RUN);
    bus.res_valid = (r_state == DONE);
    bus.res       = w_acc;
    bus.wrap      = w_wrap;
    w_clr         = !bus.abort && (r_state == IDLE) && bus.start;
    w_en          = !bus.abort && w_beat;
  end

  mac_acc_dp #(
    .W(W)
  ) u_acc_dp (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .en   (w_en),
    .a    (bus.a_in),
    .b    (bus.b_in),
    .acc  (w_acc),
    .wrap (w_wrap)
  );

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for the 16-bit multiply-accumulate datapath.
- Accepts a job of LEN operand pairs, streams them through a multiply-add accumulator, and returns the dot product.
- Uses valid/ready streaming and a result handshake, with a sticky wrap flag.
- Sits between a job issuer (host/test-generator logic) and the MAC; it owns accumulator clearing and enabling, which the bare MAC lacks.

Parameters:
- W, 16, operand/accumulator width; all arithmetic is modulo 2^W.
- CNT_W, 8, width of the job length field; max job LEN = 2^CNT_W - 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request pulse; accepted only in IDLE.
- len  in  CNT_W  number of operand pairs; sampled when start is accepted.
- abort  in  1  synchronous job cancel.
- busy  out  1  high whenever state != IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller accepts operand pair.
- a_in  in  W  operand A.
- b_in  in  W  operand B.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res  out  W  accumulated result.
- wrap  out  1  sticky flag: some product or addition in this job exceeded W bits.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, acc=0, cnt=0, wrap=0. All outputs are 0 while rst is low and after release.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - acc<=0, wrap<=0, cnt<=len.
  - If len==0, go to DONE (res=0, wrap=0).
  - Otherwise go to RUN.
- RUN:
  - in_ready=1. A beat is in_valid&&in_ready.
  - On a beat:
    - p = a_in*b_in (2W-bit).
    - s = acc + p[W-1:0] (W+1-bit).
    - acc <= s[W-1:0].
    - wrap <= wrap | (p[2W-1:W]!=0) | s[W].
    - cnt <= cnt-1.
  - A beat with cnt==1 goes to DONE.
  - No beat: hold all state.
- DONE:
  - res_valid=1. res=acc (registered, stable while res_valid).
  - On res_ready, go to IDLE.
- res and wrap keep their final values in IDLE until the next accepted start.
- Latency:
  - res_valid rises in the cycle after the final beat, or the cycle after start when len==0.
  - Full throughput is one pair per cycle.
- in_ready is a combinational decode of state only; it never depends on in_valid.
- start while busy is ignored, with no side effects.
- abort=1 in any state: next state IDLE, cnt<=0; acc and wrap hold.
  - abort has priority over a beat, res_ready and start in the same cycle.
  - An aborted job never raises res_valid.
- res_ready in the same cycle as DONE entry has no effect; only DONE-state handshakes count.
- Simultaneous in_valid outside RUN is ignored.

Decomposition:
- Package mac_seq_pkg:
  - State enum (IDLE/RUN/DONE).
  - Default W and CNT_W constants.
  - Function mac_step(acc,a,b) returning {wrap_bit, next_acc}.
- Sub-module mac_acc_dp holds the multiply-add plus accumulator register.
  - Inputs: clr, en, a, b.
  - Outputs: acc, wrap.
- mac_seq_ctrl keeps only the FSM, counter and handshakes.

Test Plan:
- Basic job: start len=3; beats (2,3),(4,5),(1,7) on consecutive cycles -> res_valid the cycle after the third beat, res=0x0021, wrap=0, busy drops the cycle after the res_ready handshake.
- Zero length: start len=0 -> res_valid next cycle, res=0x0000, in_ready never asserted.
- Wrap detection:
  - len=2, beats (0x8000,0x0002),(0xFFFF,0x0001) -> res=0xFFFF, wrap=1.
  - Next job len=1, (3,3) -> res=0x0009, wrap=0.
- Backpressure: len=4 with in_valid gaps of 0-3 cycles, res_ready low for 5 cycles, start pulsed while busy -> res stable and correct (sum of products), res_valid held, extra starts ignored.
- Abort: len=5, abort after 2 beats, with in_valid=1 that cycle -> next cycle IDLE, busy=0, res_valid never rises; then len=1, (3,3) -> res=0x0009.
- Async reset: assert rst low mid-RUN between clock edges -> busy, in_ready, res_valid, res, wrap all go to 0 immediately; after release, a normal job completes correctly.
